fp_div_scheduler: RTL and testbench

Shares one registered floating-point divider (DW-bit operands, result registered one clock after operands and enable are presented) between N_REQ requesters. Each cycle it picks one eligible requester by round-robin, drives that requester's operands into the divider, and tracks the request through the divider latency with a tag pipeline. It steers each result into a per-requester holding register, which the requester drains with a valid/ready handshake. It sits between the FPU issue logic and the shared divider instance.

---
 rtl/fp_div_scheduler.sv | 122 ++++++++++++
 tb/tb_fp_div_scheduler.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_scheduler.sv
// Round-robin scheduler sharing one registered FP divider between N_REQ requesters,
// with a tag pipeline that follows each op through the divider and per-requester
// result holding registers drained by valid/ready.
module fp_div_scheduler #(
    parameter int unsigned DW      = 32,
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned DIV_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*DW-1:0]   req_a,
    input  logic [N_REQ*DW-1:0]   req_b,
    output logic [DW-1:0]         div_a,
    output logic [DW-1:0]         div_b,
    output logic                  div_en,
    input  logic [DW-1:0]         div_c,
    output logic [N_REQ-1:0]      rsp_valid,
    input  logic [N_REQ-1:0]      rsp_ready,
    output logic [N_REQ*DW-1:0]   rsp_data,
    output logic                  busy
);

    localparam int unsigned IDW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned LAST = DIV_LAT - 1;

    logic [N_REQ-1:0]           pending_q, pending_d;
    logic [N_REQ-1:0]           rsp_valid_q, rsp_valid_d;
    logic [N_REQ-1:0][DW-1:0]   rsp_data_q, rsp_data_d;
    logic [IDW-1:0]             ptr_q, ptr_d;
    logic [DIV_LAT-1:0]         tv_q, tv_d;
    logic [DIV_LAT-1:0][IDW-1:0] tid_q, tid_d;

    logic [N_REQ-1:0]           eligible_c;
    logic [N_REQ-1:0]           grant_c;
    logic [N_REQ-1:0]           drain_c;
    logic                       grant_any_c;
    logic [IDW-1:0]             winner_c;

    // Round-robin pick starting at ptr; no grants while reset is held
    always_comb begin
        int unsigned idx;
        idx         = 0;
        eligible_c  = rst ? (req_valid & ~pending_q) : '0;
        grant_any_c = 1'b0;
        winner_c    = '0;
        grant_c     = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (32'(ptr_q) + k) % N_REQ;
            if (!grant_any_c && eligible_c[idx]) begin
                grant_any_c = 1'b1;
                winner_c    = IDW'(idx);
            end
        end
        grant_c[winner_c] = grant_any_c;
    end

    // Operand mux into the shared divider
    always_comb begin
        div_a  = '0;
        div_b  = '0;
        div_en = grant_any_c;
        if (grant_any_c) begin
            div_a = req_a[32'(winner_c)*DW +: DW];
            div_b = req_b[32'(winner_c)*DW +: DW];
        end
    end

    // Next state: pointer, pending flags, tag shift, result capture and drain
    always_comb begin
        ptr_d       = ptr_q;
        drain_c     = rsp_valid_q & rsp_ready;
        pending_d   = (pending_q & ~drain_c) | grant_c;
        rsp_valid_d = rsp_valid_q & ~drain_c;
        rsp_data_d  = rsp_data_q;
        tv_d        = '0;
        tid_d       = '0;

        if (grant_any_c) begin
            ptr_d = (32'(winner_c) == N_REQ - 1) ? '0 : winner_c + IDW'(1);
        end

        tv_d[0]  = grant_any_c;
        tid_d[0] = winner_c;
        for (int unsigned s = 1; s < DIV_LAT; s++) begin
            tv_d[s]  = tv_q[s-1];
            tid_d[s] = tid_q[s-1];
        end

        // Pending blocks re-issue, so capture never collides with a drain of the same slot
        if (tv_q[LAST]) begin
            rsp_valid_d[tid_q[LAST]] = 1'b1;
            rsp_data_d[tid_q[LAST]]  = div_c;
        end
    end

    // State registers; reset discards in-flight tags and held results
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q       <= '0;
            pending_q   <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            tv_q        <= '0;
            tid_q       <= '0;
        end else begin
            ptr_q       <= ptr_d;
            pending_q   <= pending_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            tv_q        <= tv_d;
            tid_q       <= tid_d;
        end
    end

    assign req_ready = grant_c;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (|tv_q) | (|rsp_valid_q);

endmodule

// File: tb/tb_fp_div_scheduler.sv
// Directed bench for fp_div_scheduler with a one-cycle registered stub divider.
module tb_fp_div_scheduler;

    localparam int unsigned DW      = 32;
    localparam int unsigned N_REQ   = 4;
    localparam int unsigned DIV_LAT = 1;

    logic                  clk;
    logic                  rst;
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ*DW-1:0]   req_a;
    logic [N_REQ*DW-1:0]   req_b;
    logic [DW-1:0]         div_a;
    logic [DW-1:0]         div_b;
    logic                  div_en;
    logic [DW-1:0]         div_c;
    logic [N_REQ-1:0]      rsp_valid;
    logic [N_REQ-1:0]      rsp_ready;
    logic [N_REQ*DW-1:0]   rsp_data;
    logic                  busy;

    int total;
    int bad;

    fp_div_scheduler #(.DW(DW), .N_REQ(N_REQ), .DIV_LAT(DIV_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_en    (div_en),
        .div_c     (div_c),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub divider: known quotients for the vectors used, zero for a zero divisor
    function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'h0) return 32'h0;
        case ({a, b})
            64'h40C00000_40000000: return 32'h40400000;
            64'h41200000_40A00000: return 32'h40000000;
            64'h40800000_40800000: return 32'h3F800000;
            64'h3F800000_40000000: return 32'h3F000000;
            default:               return a ^ {b[15:0], b[31:16]};
        endcase
    endfunction

    always @(posedge clk) div_c <= fdiv(div_a, div_b);

    logic [31:0] op_a [N_REQ];
    logic [31:0] op_b [N_REQ];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
    endtask

    function automatic logic [31:0] rsp_of(input int i);
        return rsp_data[i*DW +: DW];
    endfunction

    task automatic load_table_ops();
        op_a[0] = 32'h40C00000; op_b[0] = 32'h40000000;
        op_a[1] = 32'h41200000; op_b[1] = 32'h40A00000;
        op_a[2] = 32'h40800000; op_b[2] = 32'h40800000;
        op_a[3] = 32'h3F800000; op_b[3] = 32'h40000000;
        for (int i = 0; i < N_REQ; i++) set_op(i, op_a[i], op_b[i]);
    endtask

    // Holds reset for two edges, releases it just after an edge
    task automatic reset_dut();
        rst = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    task automatic drain_idle();
        req_valid = '0;
        rsp_ready = '1;
        for (int i = 0; i < 4; i++) cyc();
        #2;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL drain_busy got=%b exp=0", busy); end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rsp_ready = '0;
        req_a = '0;
        req_b = '0;
        set_op(0, 32'h40C00000, 32'h40000000);
        req_valid = 4'b0001;
        #3;
        total++;
        if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        total++;
        if (div_en !== 1'b0) begin bad++; $display("FAIL reset_div_en got=%b exp=0", div_en); end
        total++;
        if (div_a !== 32'h0 || div_b !== 32'h0) begin bad++; $display("FAIL reset_div_ops got=%h/%h exp=0/0", div_a, div_b); end
        total++;
        if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
        total++;
        if (rsp_data !== '0) begin bad++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single();
        cyc();
        rst = 1'b1;
        req_valid = 4'b0001;
        #2;
        total++;
        if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b exp=0001", req_ready); end
        total++;
        if (div_en !== 1'b1) begin bad++; $display("FAIL single_div_en got=%b exp=1", div_en); end
        total++;
        if (div_a !== 32'h40C00000 || div_b !== 32'h40000000)
            begin bad++; $display("FAIL single_div_ops got=%h/%h exp=40c00000/40000000", div_a, div_b); end
        cyc();
        req_valid = '0;
        #2;
        total++;
        if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL single_early_rsp got=%b exp=0000", rsp_valid); end
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy); end
        cyc();
        #2;
        total++;
        if (rsp_valid !== 4'b0001) begin bad++; $display("FAIL single_rsp_valid got=%b exp=0001", rsp_valid); end
        total++;
        if (rsp_of(0) !== 32'h40400000) begin bad++; $display("FAIL single_rsp_data got=%h exp=40400000", rsp_of(0)); end
        rsp_ready = 4'b0001;
        cyc();
        #2;
        total++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0)
            begin bad++; $display("FAIL single_drain got=%b/%b exp=0000/0", rsp_valid, busy); end
    endtask

    task automatic test_contention();
        int r;
        load_table_ops();
        reset_dut();
        rsp_ready = '1;
        req_valid = '1;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) cyc();
            #2;
            total++;
            if (req_ready !== 4'(1 << (c % 4)))
                begin bad++; $display("FAIL contention_grant c=%0d got=%b exp=%b", c, req_ready, 4'(1 << (c % 4))); end
            if (c >= 2) begin
                r = (c - 2) % 4;
                total++;
                if (rsp_valid !== 4'(1 << r))
                    begin bad++; $display("FAIL contention_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, 4'(1 << r)); end
                total++;
                if (rsp_of(r) !== fdiv(op_a[r], op_b[r]))
                    begin bad++; $display("FAIL contention_rsp_data r=%0d got=%h exp=%h", r, rsp_of(r), fdiv(op_a[r], op_b[r])); end
            end else begin
                total++;
                if (rsp_valid !== 4'b0000)
                    begin bad++; $display("FAIL contention_early_rsp c=%0d got=%b exp=0000", c, rsp_valid); end
            end
        end
        cyc();
        drain_idle();
    endtask

    task automatic test_fairness();
        reset_dut();
        rsp_ready = '1;
        req_valid = 4'b0010;
        #2;
        total++;
        if (req_ready !== 4'b0010) begin bad++; $display("FAIL fair_setup_grant got=%b exp=0010", req_ready); end
        cyc();
        req_valid = '0;
        cyc();
        cyc();
        cyc();
        // pointer now 2; requesters 0 and 3 compete
        req_valid = 4'b1001;
        #2;
        total++;
        if (req_ready !== 4'b1000) begin bad++; $display("FAIL fair_first got=%b exp=1000", req_ready); end
        cyc();
        #2;
        total++;
        if (req_ready !== 4'b0001) begin bad++; $display("FAIL fair_second got=%b exp=0001", req_ready); end
        cyc();
        drain_idle();
    endtask

    task automatic test_backpressure();
        bit seen;
        int comp0;
        int comp2;
        comp0 = 0;
        comp2 = 0;
        seen = 1'b0;
        load_table_ops();
        rsp_ready = 4'b1101;
        req_valid = 4'b0111;
        for (int i = 0; i < 12 && !seen; i++) begin
            if (i > 0) cyc();
            #2;
            if (rsp_valid[0]) comp0++;
            if (rsp_valid[2]) comp2++;
            if (rsp_valid[1]) seen = 1'b1;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL bp_rsp1_timeout got=0 exp=1"); end
        for (int i = 0; i < 10; i++) begin
            cyc();
            #2;
            total++;
            if (rsp_valid[1] !== 1'b1) begin bad++; $display("FAIL bp_hold_valid i=%0d got=%b exp=1", i, rsp_valid[1]); end
            total++;
            if (rsp_of(1) !== 32'h40000000) begin bad++; $display("FAIL bp_hold_data i=%0d got=%h exp=40000000", i, rsp_of(1)); end
            total++;
            if (req_ready[1] !== 1'b0) begin bad++; $display("FAIL bp_regrant i=%0d got=%b exp=0", i, req_ready[1]); end
            if (rsp_valid[0]) begin
                comp0++;
                total++;
                if (rsp_of(0) !== 32'h40400000) begin bad++; $display("FAIL bp_data0 got=%h exp=40400000", rsp_of(0)); end
            end
            if (rsp_valid[2]) begin
                comp2++;
                total++;
                if (rsp_of(2) !== 32'h3F800000) begin bad++; $display("FAIL bp_data2 got=%h exp=3f800000", rsp_of(2)); end
            end
        end
        total++;
        if (comp0 < 2 || comp2 < 2) begin bad++; $display("FAIL bp_others_progress got=%0d/%0d exp>=2/2", comp0, comp2); end
        req_valid = '0;
        rsp_ready = '1;
        cyc();
        #2;
        total++;
        if (rsp_valid[1] !== 1'b0) begin bad++; $display("FAIL bp_release got=%b exp=0", rsp_valid[1]); end
        drain_idle();
    endtask

    task automatic test_zero();
        rsp_ready = '1;
        set_op(2, 32'h40400000, 32'h00000000);
        req_valid = 4'b0100;
        #2;
        total++;
        if (req_ready !== 4'b0100 || div_a !== 32'h40400000 || div_b !== 32'h0)
            begin bad++; $display("FAIL zero_issue got=%b %h/%h exp=0100 40400000/0", req_ready, div_a, div_b); end
        cyc();
        req_valid = '0;
        #2;
        total++;
        if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL zero_early got=%b exp=0000", rsp_valid); end
        cyc();
        #2;
        total++;
        if (rsp_valid !== 4'b0100) begin bad++; $display("FAIL zero_valid got=%b exp=0100", rsp_valid); end
        total++;
        if (rsp_of(2) !== 32'h0) begin bad++; $display("FAIL zero_data got=%h exp=0", rsp_of(2)); end
        drain_idle();
    endtask

    task automatic test_reset_midflight();
        load_table_ops();
        rsp_ready = '1;
        req_valid = 4'b0010;
        #2;
        total++;
        if (req_ready !== 4'b0010) begin bad++; $display("FAIL mid_grant got=%b exp=0010", req_ready); end
        cyc();
        req_valid = 4'b1101;
        rst = 1'b0;
        #2;
        total++;
        if (req_ready !== 4'b0000 || div_en !== 1'b0 || div_a !== 32'h0 || div_b !== 32'h0)
            begin bad++; $display("FAIL mid_rst_issue got=%b %b %h/%h exp=0000 0 0/0", req_ready, div_en, div_a, div_b); end
        total++;
        if (rsp_valid !== 4'b0000 || rsp_data !== '0 || busy !== 1'b0)
            begin bad++; $display("FAIL mid_rst_state got=%b %h %b exp=0000 0 0", rsp_valid, rsp_data, busy); end
        cyc();
        rst = 1'b1;
        req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) cyc();
            #2;
            total++;
            if (rsp_valid !== 4'b0000 || busy !== 1'b0)
                begin bad++; $display("FAIL mid_ghost i=%0d got=%b/%b exp=0000/0", i, rsp_valid, busy); end
        end
        cyc();
        req_valid = 4'b1011;
        #2;
        total++;
        if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_ptr_reset got=%b exp=0001", req_ready); end
        cyc();
        drain_idle();
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_backpressure();
        test_zero();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
